// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array result drain.
// Result element e of the flattened Y bus sits at bit offset result_slice(e), element 0 at the MSBs.
package sa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    SETTLE,
    CAPTURE,
    STREAM
  } sa_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int RES_W     = 2 * DEF_WIDTH;

  function automatic int result_slice(input int e, input int n, input int res_w);
    return (n - e - 1) * res_w;
  endfunction

endpackage

// File: rtl/sa_snapshot_bank.sv
// N x RW register file: whole Y bus loaded in one cycle, one word read out through a mux.
// Combinational read of registered words; no backpressure of its own.
module sa_snapshot_bank
  import sa_pkg::*;
#(
  parameter int N     = 16,
  parameter int RW    = RES_W,
  parameter int IDX_W = 4
) (
  input  logic              CLK,
  input  logic              load,
  input  logic [N*RW-1:0]   y,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [RW-1:0]     rd_data
);

  logic [RW-1:0] bank [N];

  // Contents are only meaningful after a load, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (load) begin
      for (int e = 0; e < N; e++) begin
        bank[e] <= y[result_slice(e, N, RW) +: RW];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int e = 0; e < N; e++) begin
      if (rd_idx == IDX_W'(e)) rd_data = bank[e];
    end
  end

endmodule

// File: rtl/sa_result_drain.sv
// Tracks an SA compute window, snapshots Y once settled, then streams N words row-major.
// First word max(k_len,1)+LAT+1 cycles after start; registered outputs hold while out_ready is low.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HPE   = 4,
  parameter int VPE   = 4,
  parameter int LAT   = HPE + VPE - 1,
  parameter int KW    = 16,
  localparam int RW    = 2 * WIDTH,
  localparam int N     = HPE * VPE,
  localparam int ROW_W = (HPE > 1) ? $clog2(HPE) : 1,
  localparam int COL_W = (VPE > 1) ? $clog2(VPE) : 1,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  input  logic [N*RW-1:0]   Y,
  output logic [RW-1:0]     out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              start_ignored
);

  localparam int WAIT_W = (LAT > 1) ? $clog2(LAT) : 1;

  if (LAT < 1) begin : g_lat_check
    $error("sa_result_drain: LAT must be at least 1");
  end

  sa_state_t          state, state_nxt;
  logic [KW-1:0]      beat_cnt, beat_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt, idx_p1;
  logic [ROW_W-1:0]   row_nxt;
  logic [COL_W-1:0]   col_nxt;
  logic [RW-1:0]      data_nxt, rd_data;
  logic               vld_nxt, last_nxt, done_nxt, ign_nxt, cap;
  logic               accept;

  assign accept = out_valid && out_ready;
  assign idx_p1 = idx + 1'b1;
  assign busy   = (state != IDLE);

  sa_snapshot_bank #(
    .N     (N),
    .RW    (RW),
    .IDX_W (IDX_W)
  ) u_bank (
    .CLK     (CLK),
    .load    (cap),
    .y       (Y),
    .rd_idx  (idx_p1),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    wait_nxt  = wait_cnt;
    idx_nxt   = idx;
    row_nxt   = out_row;
    col_nxt   = out_col;
    data_nxt  = out_data;
    vld_nxt   = out_valid;
    last_nxt  = out_last;
    done_nxt  = 1'b0;
    ign_nxt   = start && (state != IDLE);
    cap       = 1'b0;
    case (state)
      IDLE: begin
        // The start cycle is itself the first beat, so a one-beat job skips FEED.
        if (start) begin
          if (k_len <= KW'(1)) begin
            state_nxt = SETTLE;
            wait_nxt  = WAIT_W'(LAT - 1);
          end else begin
            state_nxt = FEED;
            beat_nxt  = k_len - 1'b1;
          end
        end
      end
      FEED: begin
        beat_nxt = beat_cnt - 1'b1;
        if (beat_cnt == KW'(1)) begin
          state_nxt = SETTLE;
          wait_nxt  = WAIT_W'(LAT - 1);
        end
      end
      SETTLE: begin
        if (wait_cnt == '0) state_nxt = CAPTURE;
        else                wait_nxt  = wait_cnt - 1'b1;
      end
      CAPTURE: begin
        // Word 0 bypasses the bank so it is valid the cycle right after capture.
        cap       = 1'b1;
        state_nxt = STREAM;
        idx_nxt   = '0;
        row_nxt   = '0;
        col_nxt   = '0;
        vld_nxt   = 1'b1;
        last_nxt  = (N == 1);
        data_nxt  = Y[result_slice(0, N, RW) +: RW];
      end
      STREAM: begin
        if (accept) begin
          if (out_last) begin
            state_nxt = IDLE;
            vld_nxt   = 1'b0;
            last_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt  = idx_p1;
            data_nxt = rd_data;
            last_nxt = (idx_p1 == IDX_W'(N - 1));
            if (out_col == COL_W'(VPE - 1)) begin
              col_nxt = '0;
              row_nxt = out_row + 1'b1;
            end else begin
              col_nxt = out_col + 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      wait_cnt      <= '0;
      idx           <= '0;
      out_row       <= '0;
      out_col       <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      done          <= 1'b0;
      start_ignored <= 1'b0;
    end else begin
      state         <= state_nxt;
      beat_cnt      <= beat_nxt;
      wait_cnt      <= wait_nxt;
      idx           <= idx_nxt;
      out_row       <= row_nxt;
      out_col       <= col_nxt;
      out_data      <= data_nxt;
      out_valid     <= vld_nxt;
      out_last      <= last_nxt;
      done          <= done_nxt;
      start_ignored <= ign_nxt;
    end
  end

endmodule
